// File: rtl/chess_clock_multi_pkg.sv
// Shared state encoding and time-control tables for the multi-player game clock.
package chess_clock_multi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } clock_state_t;

  localparam int unsigned MODE_BASE_SEC [4] = '{60, 180, 300, 600};
  localparam int unsigned MODE_INC_SEC  [4] = '{0, 2, 3, 5};

endpackage

// File: rtl/chess_clock_multi_sec_to_bcd_mmss.sv
// Seconds to mm:ss BCD {min_t,min_u,sec_t,sec_u}; registered, 1-cycle latency, no backpressure.
module chess_clock_multi_sec_to_bcd_mmss #(
  parameter int          SEC_W     = 13,
  parameter logic [15:0] RESET_BCD = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEC_W-1:0] sec,
  output logic [15:0]      bcd
);

  int unsigned mins;
  int unsigned secs;
  logic [15:0] bcd_nxt;

  always_comb begin
    mins    = 32'(sec) / 32'd60;
    secs    = 32'(sec) % 32'd60;
    bcd_nxt = {4'(mins / 32'd10), 4'(mins % 32'd10), 4'(secs / 32'd10), 4'(secs % 32'd10)};
  end

  always_ff @(posedge clk) begin
    if (reset) bcd <= RESET_BCD;
    else       bcd <= bcd_nxt;
  end

endmodule

// File: rtl/chess_clock_multi.sv
// N-player countdown game clock with Fischer increment, pause/resume and sticky flag detection.
// Control pulses act on the next edge; bcd_mmss trails time_left/active_player by one cycle.
module chess_clock_multi
  import chess_clock_multi_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_PLAYERS = 2,
  parameter int SEC_W       = 13,
  parameter int MAX_SEC     = 5999
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load,
  input  logic [1:0]                       mode_sel,
  input  logic                             start,
  input  logic                             pause,
  input  logic                             switch_turn,
  output logic [$clog2(NUM_PLAYERS)-1:0]   active_player,
  output logic [NUM_PLAYERS*SEC_W-1:0]     time_left,
  output logic                             running,
  output logic                             time_up,
  output logic [$clog2(NUM_PLAYERS)-1:0]   flag_player,
  output logic [15:0]                      bcd_mmss
);

  localparam int AW = $clog2(NUM_PLAYERS);
  localparam int PW = $clog2(CLK_FREQ_HZ);

  clock_state_t     state, state_nxt;
  logic [PW-1:0]    presc;
  logic [SEC_W-1:0] tl [NUM_PLAYERS];
  logic [1:0]       mode;
  logic [SEC_W-1:0] act_t, dec_t, inc_t;
  logic [31:0]      sum;
  logic [AW-1:0]    next_player;
  logic             tick, do_switch, flag;

  assign act_t   = tl[active_player];
  assign running = (state == RUNNING);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Priority: load, then pause, then flag, then switch; a flag swallows a same-cycle switch.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    do_switch = 1'b0;
    flag      = 1'b0;
    if (load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, PAUSED: if (start && !pause) state_nxt = RUNNING;
        RUNNING: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else begin
            tick      = (presc == PW'(CLK_FREQ_HZ - 1));
            do_switch = switch_turn;
            if (tick && act_t == SEC_W'(1)) begin
              flag      = 1'b1;
              do_switch = 1'b0;
              state_nxt = EXPIRED;
            end
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    dec_t       = tick ? act_t - SEC_W'(1) : act_t;
    sum         = 32'(dec_t) + MODE_INC_SEC[mode];
    inc_t       = (sum > 32'(MAX_SEC)) ? SEC_W'(MAX_SEC) : sum[SEC_W-1:0];
    next_player = (active_player == AW'(NUM_PLAYERS - 1)) ? '0 : AW'(active_player + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) tl[p] <= SEC_W'(MODE_BASE_SEC[0]);
      mode          <= 2'd0;
      active_player <= '0;
      presc         <= '0;
      time_up       <= 1'b0;
      flag_player   <= '0;
    end else if (load) begin
      for (int p = 0; p < NUM_PLAYERS; p++) tl[p] <= SEC_W'(MODE_BASE_SEC[mode_sel]);
      mode          <= mode_sel;
      active_player <= '0;
      presc         <= '0;
      time_up       <= 1'b0;
    end else if (flag) begin
      tl[active_player] <= '0;
      time_up           <= 1'b1;
      flag_player       <= active_player;
      presc             <= '0;
    end else if (do_switch) begin
      tl[active_player] <= inc_t;
      active_player     <= next_player;
      presc             <= '0;
    end else if (state == RUNNING && !pause) begin
      tl[active_player] <= dec_t;
      presc             <= tick ? '0 : presc + 1'b1;
    end
  end

  always_comb begin
    time_left = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) time_left[p*SEC_W +: SEC_W] = tl[p];
  end

  chess_clock_multi_sec_to_bcd_mmss #(
    .SEC_W     (SEC_W),
    .RESET_BCD (16'h0100)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .sec   (act_t),
    .bcd   (bcd_mmss)
  );

endmodule
